// File: rtl/parallel_in_serial_out_handshake_16_bit_pkg.sv
// parallel_in_serial_out_handshake_16_bit_pkg: shared state encoding and sizing helpers for the serialiser
package parallel_in_serial_out_handshake_16_bit_pkg;
    localparam logic IDLE = 1'b0;
    localparam logic SHIFT = 1'b1;
    localparam int DEFAULT_DATA_WIDTH = 16;
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/parallel_in_serial_out_handshake_16_bit.sv
// parallel_in_serial_out_handshake_16_bit: valid/ready loaded word shifted out one bit per falling edge
module parallel_in_serial_out_handshake_16_bit
    import parallel_in_serial_out_handshake_16_bit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    input  logic                  Shift_Enable_In,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_First_Out,
    output logic                  Frame_Last_Out,
    output logic                  Busy_Out
);
    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    logic state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0] cnt;
    logic at_last, load, consume;
    assign Busy_Out = (state == SHIFT);
    assign Serial_Valid_Out = Busy_Out;
    assign at_last = Busy_Out && (cnt == LAST);
    assign Load_Ready_Out = (state == IDLE) || (at_last && Shift_Enable_In);
    assign load = Load_Valid_In && Load_Ready_Out;
    assign consume = Serial_Valid_Out && Shift_Enable_In;
    // shreg holds the bits not yet presented, already aligned so the next one sits at the exit end
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            Serial_Data_Out <= IDLE_LEVEL;
            Frame_First_Out <= 1'b0;
            Frame_Last_Out <= 1'b0;
        end else if (load) begin
            state <= SHIFT;
            shreg <= MSB_FIRST ? (Parallel_Data_In << 1) : (Parallel_Data_In >> 1);
            cnt <= '0;
            Serial_Data_Out <= MSB_FIRST ? Parallel_Data_In[DATA_WIDTH-1] : Parallel_Data_In[0];
            Frame_First_Out <= 1'b1;
            Frame_Last_Out <= (DATA_WIDTH == 1);
        end else if (consume) begin
            if (at_last) begin
                state <= IDLE;
                Serial_Data_Out <= IDLE_LEVEL;
                Frame_First_Out <= 1'b0;
                Frame_Last_Out <= 1'b0;
            end else begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                cnt <= cnt + CW'(1);
                Serial_Data_Out <= MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
                Frame_First_Out <= 1'b0;
                Frame_Last_Out <= ((cnt + CW'(1)) == LAST);
            end
        end
    end
endmodule

// File: tb/tb_parallel_in_serial_out_handshake_16_bit.sv
// tb_parallel_in_serial_out_handshake_16_bit: directed scenarios against hand-derived bit streams
module tb_parallel_in_serial_out_handshake_16_bit;
    logic clk = 1'b1;
    logic rst;
    logic [15:0] din;
    logic vin, sen;
    logic rdy, sdo, sv, ff, fl, busy;
    logic rdy_l, sdo_l, sv_l, ff_l, fl_l, busy_l;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parallel_in_serial_out_handshake_16_bit dut (
        .Clk_In(clk), .Reset_In(rst), .Parallel_Data_In(din), .Load_Valid_In(vin),
        .Load_Ready_Out(rdy), .Shift_Enable_In(sen), .Serial_Data_Out(sdo),
        .Serial_Valid_Out(sv), .Frame_First_Out(ff), .Frame_Last_Out(fl), .Busy_Out(busy)
    );

    parallel_in_serial_out_handshake_16_bit #(.MSB_FIRST(1'b0)) dut_lsb (
        .Clk_In(clk), .Reset_In(rst), .Parallel_Data_In(din), .Load_Valid_In(vin),
        .Load_Ready_Out(rdy_l), .Shift_Enable_In(sen), .Serial_Data_Out(sdo_l),
        .Serial_Valid_Out(sv_l), .Frame_First_Out(ff_l), .Frame_Last_Out(fl_l), .Busy_Out(busy_l)
    );

    task automatic step;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din = 16'($urandom);
        vin = 1'($urandom);
        sen = 1'($urandom);
        #1;
        checks++;
        if ({sdo, sv, rdy, busy, ff, fl} !== 6'b001000) begin
            errors++;
            $display("FAIL reset: sdo/sv/rdy/busy/ff/fl got %b want 001000", {sdo, sv, rdy, busy, ff, fl});
        end
        step();
        checks++;
        if ({sdo, sv, rdy, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_clocked: sdo/sv/rdy/busy got %b want 0010", {sdo, sv, rdy, busy});
        end
        vin = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if ({sv, rdy} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: sv/rdy got %b want 01", {sv, rdy});
        end
    endtask

    task automatic test_single_frame;
        logic [15:0] w = 16'hA5C3;
        din = w;
        vin = 1'b1;
        sen = 1'b1;
        step();
        vin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({sdo, sv, ff, fl, rdy} !== {w[15-i], 1'b1, i == 0, i == 15, i == 15}) begin
                errors++;
                $display("FAIL single bit%0d: sdo/sv/ff/fl/rdy got %b want %b", i,
                         {sdo, sv, ff, fl, rdy}, {w[15-i], 1'b1, i == 0, i == 15, i == 15});
            end
            step();
        end
        checks++;
        if ({sdo, sv, busy, ff, fl, rdy} !== 6'b000001) begin
            errors++;
            $display("FAIL single_idle: sdo/sv/busy/ff/fl/rdy got %b want 000001", {sdo, sv, busy, ff, fl, rdy});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] s = {16'hFFFF, 16'h0001};
        din = 16'hFFFF;
        vin = 1'b1;
        sen = 1'b1;
        step();
        din = 16'h0001;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) vin = 1'b0;
            checks++;
            if ({sdo, sv, ff, fl, rdy} !== {s[31-i], 1'b1, i == 0 || i == 16, i == 15 || i == 31, i == 15 || i == 31}) begin
                errors++;
                $display("FAIL b2b bit%0d: sdo/sv/ff/fl/rdy got %b want %b", i, {sdo, sv, ff, fl, rdy},
                         {s[31-i], 1'b1, i == 0 || i == 16, i == 15 || i == 31, i == 15 || i == 31});
            end
            step();
        end
        checks++;
        if ({sv, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: sv/busy got %b want 00", {sv, busy});
        end
    endtask

    task automatic test_stall;
        logic [15:0] w = 16'h8001;
        din = w;
        vin = 1'b1;
        sen = 1'b1;
        step();
        vin = 1'b0;
        din = 16'h7FFE;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({sdo, sv, ff, fl} !== {w[15-i], 1'b1, i == 0, i == 15}) begin
                errors++;
                $display("FAIL stall bit%0d: sdo/sv/ff/fl got %b want %b", i, {sdo, sv, ff, fl},
                         {w[15-i], 1'b1, i == 0, i == 15});
            end
            if (i == 5) begin
                sen = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    checks++;
                    if ({sdo, sv, ff, fl, rdy} !== 5'b01000) begin
                        errors++;
                        $display("FAIL stall_hold%0d: sdo/sv/ff/fl/rdy got %b want 01000", k, {sdo, sv, ff, fl, rdy});
                    end
                end
                sen = 1'b1;
            end
            step();
        end
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: sv got %b want 0", sv);
        end
        sen = 1'b1;
        step();
        checks++;
        if ({sv, sdo, rdy} !== 3'b001) begin
            errors++;
            $display("FAIL idle_enable: sv/sdo/rdy got %b want 001", {sv, sdo, rdy});
        end
    endtask

    task automatic test_bit_order;
        din = 16'h0001;
        vin = 1'b1;
        sen = 1'b1;
        step();
        vin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({sdo_l, sv_l, ff_l, fl_l} !== {i == 0, 1'b1, i == 0, i == 15}) begin
                errors++;
                $display("FAIL lsb bit%0d: sdo/sv/ff/fl got %b want %b", i, {sdo_l, sv_l, ff_l, fl_l},
                         {i == 0, 1'b1, i == 0, i == 15});
            end
            step();
        end
        checks++;
        if ({sv_l, busy_l} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_idle: sv/busy got %b want 00", {sv_l, busy_l});
        end
    endtask

    task automatic test_abort;
        logic [15:0] w = 16'h00FF;
        logic [15:0] n = 16'h1234;
        din = w;
        vin = 1'b1;
        sen = 1'b1;
        step();
        vin = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i == 3) begin
                din = n;
                vin = 1'b1;
                checks++;
                if (rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_ready: rdy got %b want 0", rdy);
                end
            end else begin
                vin = 1'b0;
            end
            checks++;
            if ({sdo, sv, ff} !== {w[15-i], 1'b1, i == 0}) begin
                errors++;
                $display("FAIL abort bit%0d: sdo/sv/ff got %b want %b", i, {sdo, sv, ff}, {w[15-i], 1'b1, i == 0});
            end
            if (i < 8) step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sdo, sv, busy, ff, fl, rdy} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_reset: sdo/sv/busy/ff/fl/rdy got %b want 000001", {sdo, sv, busy, ff, fl, rdy});
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({sv, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_resume: sv/busy got %b want 00", {sv, busy});
        end
        din = n;
        vin = 1'b1;
        step();
        vin = 1'b0;
        din = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({sdo, sv, ff, fl} !== {n[15-i], 1'b1, i == 0, i == 15}) begin
                errors++;
                $display("FAIL reload bit%0d: sdo/sv/ff/fl got %b want %b", i, {sdo, sv, ff, fl},
                         {n[15-i], 1'b1, i == 0, i == 15});
            end
            step();
        end
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL reload_idle: sv got %b want 0", sv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_bit_order();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
